// File: rtl/note_sequencer_pkg.sv
//------------------------------------------------------------------------------
// Module      : note_sequencer_pkg
// Description : Shared note codes, sequencer state encoding and ROM word layout.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package note_sequencer_pkg;

    localparam int NOTE_W_DEF   = 3;
    localparam int DUR_W_DEF    = 8;
    localparam int ADDR_W_DEF   = 8;
    localparam int TICK_DIV_DEF = 421875;

    localparam logic [2:0] NOTE_REST = 3'd0;
    localparam logic [2:0] NOTE_C    = 3'd1;
    localparam logic [2:0] NOTE_D    = 3'd2;
    localparam logic [2:0] NOTE_E    = 3'd3;
    localparam logic [2:0] NOTE_F    = 3'd4;
    localparam logic [2:0] NOTE_G    = 3'd5;
    localparam logic [2:0] NOTE_A    = 3'd6;
    localparam logic [2:0] NOTE_B    = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LATCH = 3'd2,
        ST_PLAY  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // ROM word is {note, dur}: duration in the low field, note above it
    localparam int ROM_DUR_LSB = 0;

    function automatic int rom_note_lsb(input int dur_w);
        return dur_w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/note_sequencer_if.sv
//------------------------------------------------------------------------------
// Module      : note_sequencer_if
// Description : Song ROM, detector and judgement signals of the note sequencer.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

interface note_sequencer_if #(
    parameter int NOTE_W = 3,
    parameter int DUR_W  = 8,
    parameter int ADDR_W = 8
);
    logic                    start;
    logic                    pause;
    logic [ADDR_W-1:0]       rom_addr;
    logic [NOTE_W+DUR_W-1:0] rom_data;
    logic [NOTE_W-1:0]       detected_note;
    logic                    detected_valid;
    logic [NOTE_W-1:0]       current_note;
    logic                    note_active;
    logic                    hit_pulse;
    logic                    miss_pulse;
    logic                    beat_tick;
    logic                    busy;
    logic                    song_done;

    // master is the sequencer itself, slave is the surrounding system
    modport master (
        input  start, pause, rom_data, detected_note, detected_valid,
        output rom_addr, current_note, note_active, hit_pulse, miss_pulse,
               beat_tick, busy, song_done
    );

    modport slave (
        output start, pause, rom_data, detected_note, detected_valid,
        input  rom_addr, current_note, note_active, hit_pulse, miss_pulse,
               beat_tick, busy, song_done
    );
endinterface

`default_nettype wire

// File: rtl/note_sequencer_beat_divider.sv
//------------------------------------------------------------------------------
// Module      : note_sequencer_beat_divider
// Description : Counts 0..TICK_DIV-1 while enabled; strobes beat_tick on wrap.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module note_sequencer_beat_divider #(
    parameter int TICK_DIV = 421875
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic beat_tick
);
    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_wrap;

    assign w_wrap    = (r_cnt == C_LAST);
    assign beat_tick = en && w_wrap;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= w_wrap ? '0 : r_cnt + CNT_W'(1);
        end
    end
endmodule

`default_nettype wire

// File: rtl/note_sequencer.sv
//------------------------------------------------------------------------------
// Module      : note_sequencer
// Description : Steps a {note, dur} song ROM on the beat tick and judges the
//               detected note against the expected one (hit / miss pulses).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module note_sequencer
    import note_sequencer_pkg::*;
#(
    parameter int NOTE_W   = NOTE_W_DEF,
    parameter int DUR_W    = DUR_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int TICK_DIV = TICK_DIV_DEF
) (
    input  logic             clk,
    input  logic             reset,
    note_sequencer_if.master bus
);
    localparam int C_NOTE_LSB = rom_note_lsb(DUR_W);

    state_t             r_state,    w_state_nxt;
    logic [ADDR_W-1:0]  r_addr,     w_addr_nxt;
    logic [NOTE_W-1:0]  r_note,     w_note_nxt;
    logic [DUR_W-1:0]   r_dur,      w_dur_nxt;
    logic               r_hit_flag, w_hit_flag_nxt;

    logic               w_tick;
    logic               w_hit;
    logic               w_miss;
    logic               w_is_note;
    logic [NOTE_W-1:0]  w_rom_note;
    logic [DUR_W-1:0]   w_rom_dur;

    assign w_rom_note = bus.rom_data[C_NOTE_LSB +: NOTE_W];
    assign w_rom_dur  = bus.rom_data[ROM_DUR_LSB +: DUR_W];
    assign w_is_note  = (r_note != NOTE_W'(NOTE_REST));

    note_sequencer_beat_divider #(
        .TICK_DIV (TICK_DIV)
    ) u_beat_divider (
        .clk       (clk),
        .reset     (reset),
        .en        (!bus.pause),
        .beat_tick (w_tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_addr     <= '0;
            r_note     <= '0;
            r_dur      <= '0;
            r_hit_flag <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_addr     <= w_addr_nxt;
            r_note     <= w_note_nxt;
            r_dur      <= w_dur_nxt;
            r_hit_flag <= w_hit_flag_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_addr_nxt     = r_addr;
        w_note_nxt     = r_note;
        w_dur_nxt      = r_dur;
        w_hit_flag_nxt = r_hit_flag;
        w_hit          = 1'b0;
        w_miss         = 1'b0;

        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    w_addr_nxt  = '0;
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_FETCH: begin
                w_state_nxt = ST_LATCH;
            end
            ST_LATCH: begin
                w_note_nxt     = w_rom_note;
                w_dur_nxt      = w_rom_dur;
                w_hit_flag_nxt = 1'b0;
                w_state_nxt    = (w_rom_dur == '0) ? ST_DONE : ST_PLAY;
            end
            ST_PLAY: begin
                // Detection is independent of the beat so it stays live under pause
                w_hit = w_is_note && bus.detected_valid &&
                        (bus.detected_note == r_note) && !r_hit_flag;
                if (w_hit) begin
                    w_hit_flag_nxt = 1'b1;
                end
                if (w_tick) begin
                    w_dur_nxt = r_dur - DUR_W'(1);
                    if (r_dur == DUR_W'(1)) begin
                        w_miss = w_is_note && !r_hit_flag && !w_hit;
                        if (r_addr == '1) begin
                            w_state_nxt = ST_DONE;
                        end else begin
                            w_addr_nxt  = r_addr + ADDR_W'(1);
                            w_state_nxt = ST_FETCH;
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign bus.rom_addr     = r_addr;
    assign bus.current_note = r_note;
    assign bus.note_active  = (r_state == ST_PLAY) && w_is_note;
    assign bus.hit_pulse    = w_hit;
    assign bus.miss_pulse   = w_miss;
    assign bus.beat_tick    = w_tick;
    assign bus.busy         = (r_state != ST_IDLE) && (r_state != ST_DONE);
    assign bus.song_done    = (r_state == ST_DONE);
endmodule

`default_nettype wire

// File: tb/tb_note_sequencer.sv
//------------------------------------------------------------------------------
// Module      : tb_note_sequencer
// Description : Directed self-checking bench for note_sequencer (TICK_DIV=4).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_note_sequencer;
    localparam int NW = 3;
    localparam int DW = 8;
    localparam int AW = 8;
    localparam int TD = 4;

    logic clk = 1'b0;
    logic reset;

    note_sequencer_if #(.NOTE_W(NW), .DUR_W(DW), .ADDR_W(AW)) bus ();

    note_sequencer #(
        .NOTE_W   (NW),
        .DUR_W    (DW),
        .ADDR_W   (AW),
        .TICK_DIV (TD)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Behavioural song ROM with one clock of read latency
    logic [NW+DW-1:0] rom [256];
    always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

    int hit_cnt  = 0;
    int miss_cnt = 0;
    int tick_cnt = 0;
    int both_cnt = 0;
    always @(negedge clk) begin
        if (bus.hit_pulse)                   hit_cnt++;
        if (bus.miss_pulse)                  miss_cnt++;
        if (bus.beat_tick)                   tick_cnt++;
        if (bus.hit_pulse && bus.miss_pulse) both_cnt++;
    end

    int n_chk  = 0;
    int n_pass = 0;
    int hit_base, miss_base, both_base, tick_base;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rom_clear();
        for (int i = 0; i < 256; i++) rom[i] = '0;
    endtask

    // Reset, pulse start, and return 1ns into the first PLAY cycle
    task automatic begin_song();
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.pause = 1'b0;
        step(2);
        reset     = 1'b0;
        hit_base  = hit_cnt;
        miss_base = miss_cnt;
        both_base = both_cnt;
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
        step(2);
    endtask

    task automatic wait_done(input string tag, input int max_cyc);
        for (int i = 0; i < max_cyc && !bus.song_done; i++) step(1);
        check(tag, bus.song_done, 1);
    endtask

    initial begin
        reset              = 1'b0;
        bus.start          = 1'b0;
        bus.pause          = 1'b0;
        bus.detected_note  = '0;
        bus.detected_valid = 1'b0;
        rom_clear();
        #2 reset = 1'b1;
        step(2);
        check("rst_addr",   bus.rom_addr, 0);
        check("rst_note",   bus.current_note, 0);
        check("rst_hit",    bus.hit_pulse, 0);
        check("rst_miss",   bus.miss_pulse, 0);
        check("rst_active", bus.note_active, 0);
        check("rst_tick",   bus.beat_tick, 0);
        check("rst_busy",   bus.busy, 0);
        check("rst_done",   bus.song_done, 0);

        // Hit on the first PLAY tick, then a rest, then end marker
        rom_clear();
        rom[0] = {3'd3, 8'd2};
        rom[1] = {3'd0, 8'd1};
        rom[2] = {3'd0, 8'd0};
        begin_song();
        check("t1_note",   bus.current_note, 3);
        check("t1_active", bus.note_active, 1);
        check("t1_tick",   bus.beat_tick, 1);
        check("t1_busy",   bus.busy, 1);
        bus.detected_note  = 3'd3;
        bus.detected_valid = 1'b1;
        #1;
        check("t1_hit",  bus.hit_pulse, 1);
        check("t1_miss", bus.miss_pulse, 0);
        step(1);
        bus.detected_valid = 1'b0;
        wait_done("t1_done", 40);
        check("t1_hits",   hit_cnt - hit_base, 1);
        check("t1_misses", miss_cnt - miss_base, 0);
        check("t1_addr",   bus.rom_addr, 2);
        check("t1_idle",   bus.busy, 0);

        // Unmatched note: miss on its 3rd beat tick
        rom_clear();
        rom[0] = {3'd5, 8'd3};
        begin_song();
        step(7);
        check("t2_no_early_miss", bus.miss_pulse, 0);
        step(1);
        check("t2_miss",      bus.miss_pulse, 1);
        check("t2_miss_tick", bus.beat_tick, 1);
        check("t2_no_hit",    bus.hit_pulse, 0);
        step(3);
        check("t2_done",   bus.song_done, 1);
        check("t2_misses", miss_cnt - miss_base, 1);
        check("t2_hits",   hit_cnt - hit_base, 0);
        check("t2_addr",   bus.rom_addr, 1);

        // Match held for the whole note: exactly one hit
        rom_clear();
        rom[0] = {3'd2, 8'd2};
        begin_song();
        bus.detected_note  = 3'd2;
        bus.detected_valid = 1'b1;
        wait_done("t3_done", 40);
        step(3);
        bus.detected_valid = 1'b0;
        check("t3_hits",   hit_cnt - hit_base, 1);
        check("t3_misses", miss_cnt - miss_base, 0);

        // Match arriving on the note-ending clock counts as a hit
        rom_clear();
        rom[0] = {3'd4, 8'd2};
        begin_song();
        step(4);
        check("t4_end_tick", bus.beat_tick, 1);
        bus.detected_note  = 3'd4;
        bus.detected_valid = 1'b1;
        #1;
        check("t4_hit",  bus.hit_pulse, 1);
        check("t4_miss", bus.miss_pulse, 0);
        step(1);
        bus.detected_valid = 1'b0;
        wait_done("t4_done", 40);
        check("t4_hits",   hit_cnt - hit_base, 1);
        check("t4_misses", miss_cnt - miss_base, 0);
        check("t4_both",   both_cnt - both_base, 0);

        // Pause for 20 clocks mid-note shifts the miss by 20 clocks
        rom_clear();
        rom[0] = {3'd5, 8'd3};
        begin_song();
        step(2);
        bus.pause = 1'b1;
        tick_base = tick_cnt;
        step(20);
        check("t5_no_tick", tick_cnt - tick_base, 0);
        check("t5_active",  bus.note_active, 1);
        bus.pause = 1'b0;
        step(5);
        check("t5_no_early_miss", bus.miss_pulse, 0);
        step(1);
        check("t5_miss", bus.miss_pulse, 1);
        wait_done("t5_done", 40);
        check("t5_misses", miss_cnt - miss_base, 1);

        // Start while busy is ignored; reset mid-PLAY aborts at once
        rom_clear();
        rom[0] = {3'd3, 8'd2};
        rom[1] = {3'd6, 8'd2};
        begin_song();
        step(7);
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
        check("t6_addr_kept", bus.rom_addr, 1);
        check("t6_note_kept", bus.current_note, 6);
        check("t6_busy",      bus.busy, 1);
        reset = 1'b1;
        #1;
        check("t6_rst_addr",   bus.rom_addr, 0);
        check("t6_rst_note",   bus.current_note, 0);
        check("t6_rst_busy",   bus.busy, 0);
        check("t6_rst_active", bus.note_active, 0);
        check("t6_rst_tick",   bus.beat_tick, 0);
        check("t6_rst_done",   bus.song_done, 0);
        step(1);
        reset = 1'b0;

        // No end marker: last address ends the song; then restart from DONE
        for (int i = 0; i < 256; i++) rom[i] = {3'd0, 8'd1};
        begin_song();
        wait_done("t7_done", 3000);
        check("t7_addr",   bus.rom_addr, 255);
        check("t7_hits",   hit_cnt - hit_base, 0);
        check("t7_misses", miss_cnt - miss_base, 0);
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
        check("t7_restart_addr", bus.rom_addr, 0);
        check("t7_restart_busy", bus.busy, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

`default_nettype wire
